seg_scan_display: RTL

- Parametrised multiplexed seven-segment scanner. Successor to the fixed 8-slot display driver and its separate divider.
- Generalised digit count, integrated prescaler, one-hot anode drive, per-digit decimal points, leading-zero suppression, anti-ghosting dead time.
- Frame-synchronous tear-free update of the displayed value.
- Sits between the CPU debug mux (F / memory read data / PC) and the board's anode and segment pins.

---
 rtl/seg_scan_display.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner: integrated prescaler, one-hot anode drive,
// frame-synchronous shadow update, leading-zero suppression and anti-ghosting dead time.
module seg_scan_display #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned DIV            = 2000,
  parameter int unsigned DEAD           = 0,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  upd,
  input  logic                  lzs,
  input  logic                  blank,
  output logic [DIGITS-1:0]     an,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  localparam int unsigned        CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned        IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]      CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0]      IDX_MAX = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0]  AN_OFF  = {DIGITS{AN_ACTIVE_LOW}};
  localparam logic [7:0]         SEG_OFF = {8{SEG_ACTIVE_LOW}};

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_q, pend_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [7:0]          seg_q, seg_d;
  logic                frame_done_q, frame_done_d;

  logic                tick;
  logic                wrap;
  logic                dead_ok;
  logic [IW-1:0]       hi_idx;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                suppress;
  logic                lit;
  logic [DIGITS-1:0]   an_oh;

  // Active-low a..g pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] r;
    r = 7'b1111111;
    case (nib)
      4'h0: r = 7'b0000001;
      4'h1: r = 7'b1001111;
      4'h2: r = 7'b0010010;
      4'h3: r = 7'b0000110;
      4'h4: r = 7'b1001100;
      4'h5: r = 7'b0100100;
      4'h6: r = 7'b0100000;
      4'h7: r = 7'b0001111;
      4'h8: r = 7'b0000000;
      4'h9: r = 7'b0000100;
      4'hA: r = 7'b0001000;
      4'hB: r = 7'b1100000;
      4'hC: r = 7'b0110001;
      4'hD: r = 7'b1000010;
      4'hE: r = 7'b0110000;
      4'hF: r = 7'b0111000;
      default: r = 7'b1111111;
    endcase
    return r;
  endfunction

  assign tick = (cnt_q == CNT_MAX);
  assign wrap = tick && (idx_q == IDX_MAX);

  // With no dead time the count comparison would be trivially true, so skip it.
  if (DEAD == 0) begin : g_no_dead
    assign dead_ok = 1'b1;
  end else begin : g_dead
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
    assign dead_ok = (cnt_q >= DEAD_C);
  end

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_d      = pend_q;
    shadow_d    = shadow_q;
    sh_dp_d     = sh_dp_q;
    if (upd) begin
      pend_data_d = data;
      pend_dp_d   = dp;
      pend_d      = 1'b1;
    end
    // Shadow only changes at the frame boundary; a coincident strobe bypasses pending.
    if (wrap) begin
      pend_d = 1'b0;
      if (upd) begin
        shadow_d = data;
        sh_dp_d  = dp;
      end else if (pend_q) begin
        shadow_d = pend_data_q;
        sh_dp_d  = pend_dp_q;
      end
    end
    frame_done_d = wrap;
  end

  always_comb begin
    hi_idx = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (shadow_q[4*k +: 4] != 4'h0) hi_idx = IW'(k);
    end
    cur_nib  = shadow_q[{idx_q, 2'b00} +: 4];
    cur_dp   = sh_dp_q[idx_q];
    suppress = lzs && (idx_q > hi_idx) && !cur_dp;
    lit      = dead_ok && !blank && !suppress;

    an_oh        = '0;
    an_oh[idx_q] = 1'b1;
    an_d         = AN_OFF;
    seg_d        = SEG_OFF;
    if (lit) begin
      an_d  = AN_ACTIVE_LOW ? ~an_oh : an_oh;
      seg_d = {hex_to_seg(cur_nib), ~cur_dp};
      if (!SEG_ACTIVE_LOW) seg_d = ~seg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      sh_dp_q      <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_q       <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      sh_dp_q      <= sh_dp_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_q       <= pend_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule
